// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with exact fill count, runtime almost-full/almost-empty
// thresholds, selectable registered or first-word-fall-through read, and sticky error flags.
module sync_fifo_ext #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int FWFT  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic             i_winc,
    input  logic             i_rinc,
    input  logic [ASIZE:0]   i_af_thresh,
    input  logic [ASIZE:0]   i_ae_thresh,
    input  logic             i_err_clr,
    output logic [DSIZE-1:0] o_rdata,
    output logic             o_wfull,
    output logic             o_rempty,
    output logic             o_walmost_full,
    output logic             o_ralmost_empty,
    output logic [ASIZE:0]   o_fill_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_CNT = (ASIZE + 1)'(DEPTH);

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wa;
    logic             w_ra;
    logic [ASIZE:0]   w_wptr_nxt;
    logic [ASIZE:0]   w_rptr_nxt;
    logic [ASIZE-1:0] w_waddr;
    logic [ASIZE-1:0] w_raddr;

    // Every flag decodes the registered count, so flags move on the same edge as the count.
    assign w_full          = (r_count == FULL_CNT);
    assign w_empty         = (r_count == '0);
    assign o_wfull         = w_full;
    assign o_rempty        = w_empty;
    assign o_walmost_full  = (r_count >= i_af_thresh);
    assign o_ralmost_empty = (r_count <= i_ae_thresh);
    assign o_fill_count    = r_count;
    assign o_overflow      = r_overflow;
    assign o_underflow     = r_underflow;

    assign w_wa       = i_winc & ~w_full;
    assign w_ra       = i_rinc & ~w_empty;
    assign w_wptr_nxt = r_wptr + (ASIZE + 1)'(w_wa);
    assign w_rptr_nxt = r_rptr + (ASIZE + 1)'(w_ra);
    assign w_waddr    = r_wptr[ASIZE-1:0];
    assign w_raddr    = r_rptr[ASIZE-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_wptr_nxt - w_rptr_nxt;
            // A new error in the clearing cycle must not be lost.
            r_overflow  <= (r_overflow  & ~i_err_clr) | (i_winc & w_full);
            r_underflow <= (r_underflow & ~i_err_clr) | (i_rinc & w_empty);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wa) begin
            r_mem[w_waddr] <= i_wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_rdata = r_mem[w_raddr];
        end else begin : g_reg
            logic [DSIZE-1:0] r_rdata;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rdata <= '0;
                end else if (w_ra) begin
                    r_rdata <= r_mem[w_raddr];
                end
            end

            assign o_rdata = r_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench: one registered-read and one FWFT instance share the same stimulus.
module tb_sync_fifo_ext;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;
    logic [4:0] af;
    logic [4:0] ae;
    logic       err_clr;

    logic [7:0] rdata0, rdata1;
    logic       wfull0, rempty0, waf0, rae0, ovf0, unf0;
    logic       wfull1, rempty1, waf1, rae1, ovf1, unf1;
    logic [4:0] fill0, fill1;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    sync_fifo_ext #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wdata(wdata), .i_winc(winc), .i_rinc(rinc),
        .i_af_thresh(af), .i_ae_thresh(ae), .i_err_clr(err_clr),
        .o_rdata(rdata0), .o_wfull(wfull0), .o_rempty(rempty0), .o_walmost_full(waf0),
        .o_ralmost_empty(rae0), .o_fill_count(fill0), .o_overflow(ovf0), .o_underflow(unf0)
    );

    sync_fifo_ext #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wdata(wdata), .i_winc(winc), .i_rinc(rinc),
        .i_af_thresh(af), .i_ae_thresh(ae), .i_err_clr(err_clr),
        .o_rdata(rdata1), .o_wfull(wfull1), .o_rempty(rempty1), .o_walmost_full(waf1),
        .o_ralmost_empty(rae1), .o_fill_count(fill1), .o_overflow(ovf1), .o_underflow(unf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed {fill, wfull, rempty, almost_full, almost_empty, overflow, underflow}.
    task automatic chk_state(input string tag, input int f, input logic ovf, input logic unf);
        logic [10:0] e;
        e = {5'(f), f == 16, f == 0, f >= int'(af), f <= int'(ae), ovf, unf};
        chk({tag, "/reg"},  {fill0, wfull0, rempty0, waf0, rae0, ovf0, unf0}, 32'(e));
        chk({tag, "/fwft"}, {fill1, wfull1, rempty1, waf1, rae1, ovf1, unf1}, 32'(e));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        winc = w; wdata = d; rinc = r; err_clr = c;
        @(posedge clk);
        #1;
        winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wdata = '0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
        af = 5'd0; ae = 5'd3;
        #12;
        chk_state("reset_af0", 0, 1'b0, 1'b0);
        chk("reset_rdata", 32'(rdata0), 32'h0);
        af = 5'd12;
        #1;
        chk_state("reset_af12", 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk_state($sformatf("fill_%0d", i + 1), i + 1, 1'b0, 1'b0);
            if (i == 0) chk("fwft_head_after_first", 32'(rdata1), 32'h00);
        end

        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk_state("overflow_set", 16, 1'b1, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk_state("overflow_set_wins", 16, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_state("overflow_clr", 16, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fwft_head_%0d", i), 32'(rdata1), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("reg_rdata_%0d", i), 32'(rdata0), 32'(i));
            chk_state($sformatf("drain_%0d", 15 - i), 15 - i, 1'b0, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rdata_hold_idle", 32'(rdata0), 32'h0F);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("underflow_set", 0, 1'b0, 1'b1);
        chk("rdata_hold_underflow", 32'(rdata0), 32'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_state("underflow_clr", 0, 1'b0, 1'b0);

        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk_state("fwft_a5_state", 1, 1'b0, 1'b0);
        chk("fwft_a5_rdata", 32'(rdata1), 32'hA5);
        chk("reg_no_read_yet", 32'(rdata0), 32'h0F);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_state("a5_read_empty", 0, 1'b0, 1'b0);
        chk("reg_a5_rdata", 32'(rdata0), 32'hA5);

        // Both requests while empty: write wins, read rejected.
        step(1'b1, 8'h11, 1'b1, 1'b0);
        q.push_back(8'h11);
        chk_state("both_at_empty", 1, 1'b0, 1'b1);
        chk("both_at_empty_rdata", 32'(rdata0), 32'hA5);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'h12 + 8'(i), 1'b0, 1'b0);
            q.push_back(8'h12 + 8'(i));
        end
        chk_state("count8", 8, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            step(1'b1, 8'h20 + 8'(k), 1'b1, 1'b0);
            exp_d = q.pop_front();
            q.push_back(8'h20 + 8'(k));
            chk($sformatf("both_reg_%0d", k), 32'(rdata0), 32'(exp_d));
            chk($sformatf("both_fwft_%0d", k), 32'(rdata1), 32'(q[0]));
        end
        chk_state("both_at_8_end", 8, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
            q.push_back(8'h50 + 8'(i));
        end
        chk_state("refill16", 16, 1'b0, 1'b0);
        af = 5'd20; ae = 5'd20;
        #1;
        chk_state("thresh_above_depth", 16, 1'b0, 1'b0);
        af = 5'd12; ae = 5'd3;

        // Both requests while full: read wins, write rejected.
        step(1'b1, 8'h77, 1'b1, 1'b0);
        exp_d = q.pop_front();
        chk("both_at_full_rdata", 32'(rdata0), 32'(exp_d));
        chk_state("both_at_full", 15, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            exp_d = q.pop_front();
            chk($sformatf("final_drain_%0d", i), 32'(rdata0), 32'(exp_d));
        end
        chk_state("final_empty", 0, 1'b0, 1'b0);

        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0);
        chk_state("pre_reset_fill", 2, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 0, 1'b0, 1'b0);
        chk("async_reset_rdata", 32'(rdata0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_reset_rdata", 32'(rdata0), 32'h3C);
        chk_state("post_reset_empty", 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
